// File: rtl/alu_div_if.sv
// Start/done handshake bundle between the pipeline and the iterative divider.
interface alu_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       div_op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output start, div_op, op1, op2,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, div_op, op1, op2,
    output busy, done, result, flags
  );
endinterface

// File: rtl/alu_div.sv
// Iterative radix-2 restoring divider for the ALU DIV opcode group.
// div_op: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Flags are {N,Z,C,V}.
// Quotient bits accumulate in the dividend register as it shifts out, so at
// the end dvd_r holds the quotient magnitude and rem_r the remainder magnitude.
module alu_div #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_div_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    FIN  = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [1:0]       op_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             ovf_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic [3:0]       flags_r;

  logic             signed_op_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic             div_zero_s;
  logic             ovf_case_s;
  logic             special_s;
  logic [WIDTH+1:0] trial_s;
  logic             borrow_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic [WIDTH-1:0] res_s;
  logic [3:0]       flags_s;

  // Capture-time decode: operand signs, magnitudes and special cases.
  always_comb begin
    signed_op_s = ~bus.div_op[0];
    a_neg_s     = signed_op_s & bus.op1[WIDTH-1];
    b_neg_s     = signed_op_s & bus.op2[WIDTH-1];
    a_mag_s     = a_neg_s ? ({WIDTH{1'b0}} - bus.op1) : bus.op1;
    b_mag_s     = b_neg_s ? ({WIDTH{1'b0}} - bus.op2) : bus.op2;
    div_zero_s  = (bus.op2 == {WIDTH{1'b0}});
    ovf_case_s  = signed_op_s
                  & (bus.op1 == {1'b1, {(WIDTH-1){1'b0}}})
                  & (bus.op2 == {WIDTH{1'b1}});
    special_s   = div_zero_s | ovf_case_s;
  end

  // Trial subtraction on the shifted partial remainder; top bit is the borrow.
  always_comb begin
    trial_s  = {1'b0, rem_r, dvd_r[WIDTH-1]} - {2'b00, dvs_r};
    borrow_s = trial_s[WIDTH+1];
  end

  // Sign fix-up and quotient/remainder selection for the FIN cycle.
  always_comb begin
    quo_fix_s = neg_q_r ? ({WIDTH{1'b0}} - dvd_r) : dvd_r;
    rem_fix_s = neg_r_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
    res_s     = op_r[1] ? rem_fix_s : quo_fix_s;
    flags_s   = {res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}), 1'b0, ovf_r};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: special cases skip the iteration phase.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = special_s ? FIN : ITER;
        end else begin
          state_s = IDLE;
        end
      end
      ITER: begin
        if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
          state_s = FIN;
        end else begin
          state_s = ITER;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per ITER cycle, FIN writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 2'b00;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      ovf_r    <= 1'b0;
      dvd_r    <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {WIDTH{1'b0}};
      flags_r  <= 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            op_r  <= bus.div_op;
            cnt_r <= CW'(WIDTH);
            dvs_r <= b_mag_s;
            if (div_zero_s) begin
              dvd_r   <= {WIDTH{1'b1}};
              rem_r   <= bus.op1;
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
              ovf_r   <= 1'b1;
            end else if (ovf_case_s) begin
              dvd_r   <= bus.op1;
              rem_r   <= {WIDTH{1'b0}};
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
              ovf_r   <= 1'b1;
            end else begin
              dvd_r   <= a_mag_s;
              rem_r   <= {WIDTH{1'b0}};
              neg_q_r <= a_neg_s ^ b_neg_s;
              neg_r_r <= a_neg_s;
              ovf_r   <= 1'b0;
            end
          end
        end
        ITER: begin
          rem_r <= borrow_s ? {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]} : trial_s[WIDTH-1:0];
          dvd_r <= {dvd_r[WIDTH-2:0], ~borrow_s};
          cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
        FIN: begin
          result_r <= res_s;
          flags_r  <= flags_s;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Registered handshake outputs: busy follows the upcoming state, done marks FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == FIN);
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.flags  = flags_r;
endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div (WIDTH=32): directed table, random ops
// against an arithmetic reference model, and handshake/reset corner sequences.
module tb_alu_div;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_div_if #(.WIDTH(32)) bus ();

  alu_div #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
    end
  endtask

  // Reference: plain SV arithmetic (signed / and % truncate toward zero).
  function automatic exp_t ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] q;
    logic [31:0] r;
    logic v;
    bit sgn;
    sgn = (op[0] == 1'b0);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; v = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0; v = 1'b1;
    end else if (sgn) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); v = 1'b0;
    end else begin
      q = a / b; r = a % b; v = 1'b0;
    end
    e.res = op[1] ? r : q;
    e.fl  = {e.res[31], (e.res == 32'd0), 1'b0, v};
    e.lat = v ? 1 : 33;
    return e;
  endfunction

  // Drive one request at a negedge; it is accepted on the following posedge (E0).
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.div_op = op; bus.op1 = a; bus.op2 = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Count edges after E0 until done; optionally inject a start pulse at cycle inj.
  task automatic wait_done(input int inj, input logic [31:0] na, input logic [31:0] nb,
                           output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == inj) begin
        bus.start = 1'b1; bus.op1 = na; bus.op2 = nb;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        if (bus.busy) busy_ok = 1'b0;
        lat = c - 1;
        break;
      end else if (!bus.busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eres,
                           input logic [3:0] efl, input int elat);
    int lat;
    bit bok;
    launch(op, a, b);
    wait_done(0, 32'd0, 32'd0, lat, bok);
    chk({name, ".res"}, bus.result, eres);
    chk({name, ".flags"}, {28'd0, bus.flags}, {28'd0, efl});
    chk({name, ".lat"}, lat, elat);
    chk({name, ".busy"}, {31'd0, bok}, 32'd1);
  endtask

  initial begin
    int lat;
    bit bok;
    int seen;
    exp_t e;
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;

    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.div_op = 2'b00; bus.op1 = 32'd0; bus.op2 = 32'd0;

    vecs[0] = '{2'b01, 32'd100,        32'd7,          32'd14,         4'b0000, 33};
    vecs[1] = '{2'b11, 32'd100,        32'd7,          32'd2,          4'b0000, 33};
    vecs[2] = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  4'b1000, 33};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  4'b1000, 33};
    vecs[4] = '{2'b01, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  4'b0000, 33};
    vecs[5] = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  4'b1001, 1};
    vecs[6] = '{2'b11, 32'd5,          32'd0,          32'd5,          4'b0001, 1};
    vecs[7] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  4'b1001, 1};
    vecs[8] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          4'b0101, 1};
    vecs[9] = '{2'b01, 32'd0,          32'd5,          32'd0,          4'b0100, 33};

    #12;
    chk("rst.busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst.done",   {31'd0, bus.done}, 32'd0);
    chk("rst.result", bus.result, 32'd0);
    chk("rst.flags",  {28'd0, bus.flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].fl, vecs[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin b = 32'hFFFF_FFFF; a = 32'h8000_0000; end
        2: b = 32'($urandom_range(1, 20));
        3: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      e = ref_model(op, a, b);
      run_check($sformatf("rnd%0d", i), op, a, b, e.res, e.fl, e.lat);
    end

    // Start pulse while busy must be ignored and not queued.
    launch(2'b01, 32'd1000, 32'd3);
    wait_done(10, 32'd50, 32'd5, lat, bok);
    chk("ign.res", bus.result, 32'd333);
    chk("ign.lat", lat, 33);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("ign.noqueue", seen, 0);
    chk("ign.hold", bus.result, 32'd333);

    // New start accepted in the done cycle.
    launch(2'b11, 32'd77, 32'd10);
    wait_done(0, 32'd0, 32'd0, lat, bok);
    chk("b2b.first", bus.result, 32'd7);
    bus.start = 1'b1; bus.div_op = 2'b00; bus.op1 = 32'hFFFF_FF9C; bus.op2 = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(0, 32'd0, 32'd0, lat, bok);
    chk("b2b.lat", lat, 33);
    chk("b2b.res", bus.result, 32'hFFFF_FFF2);
    chk("b2b.flags", {28'd0, bus.flags}, 32'h8);

    // Reset mid-operation aborts with no done pulse.
    launch(2'b01, 32'd999, 32'd9);
    for (int c = 1; c < 15; c++) @(negedge clk);
    chk("abort.busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy",   {31'd0, bus.busy}, 32'd0);
    chk("abort.done",   {31'd0, bus.done}, 32'd0);
    chk("abort.result", bus.result, 32'd0);
    chk("abort.flags",  {28'd0, bus.flags}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("abort.quiet", seen, 0);
    run_check("after_rst", 2'b01, 32'd999, 32'd9, 32'd111, 4'b0000, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
